uart_tx_scheduler: RTL and testbench



---
 rtl/uart_tx_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx serializer between NUM_REQ message sources.
// A source keeps the serializer for a whole message; bytes are paced by uart_ready falling/rising.
module uart_tx_scheduler #(
    parameter  int unsigned NUM_REQ     = 4,
    parameter  int unsigned MAX_LEN     = 64,
    parameter  int unsigned GAP_CYCLES  = 16,
    parameter  int unsigned LOW_TIMEOUT = 4,
    localparam int unsigned IDW         = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ack_o,
    output logic [7:0]             uart_data_o,
    output logic                   uart_valid_o,
    input  logic                   uart_ready_i,
    output logic                   grant_valid_o,
    output logic [IDW-1:0]         grant_id_o,
    output logic                   msg_done_o,
    output logic                   len_err_o,
    output logic                   busy_o
);

    localparam int unsigned CNTW    = $clog2(MAX_LEN + 1);
    localparam int unsigned TMR_MAX = (GAP_CYCLES > LOW_TIMEOUT) ? GAP_CYCLES : LOW_TIMEOUT;
    localparam int unsigned TMRW    = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SEND,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_RELEASE,
        S_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic              grant_valid_q, grant_valid_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]   byte_cnt_q, byte_cnt_d;
    logic              last_q, last_d;
    logic [TMRW-1:0]   tmr_q, tmr_d;
    logic              msg_done_q, msg_done_d;
    logic              len_err_q, len_err_d;

    logic              req_sel;
    logic              handoff;
    logic              pick_found;
    logic [IDW-1:0]    pick_id;
    logic [IDW-1:0]    rr_next;

    assign req_sel = req_i[grant_id_q];
    assign handoff = (state_q == S_SEND) && req_sel && uart_ready_i;
    assign rr_next = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

    // First pending request at or after rr_ptr, wrapping around.
    always_comb begin : arb_pick
        int unsigned idx;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_found && req_i[IDW'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ack_o = '0;
        if (handoff) begin
            req_ack_o[grant_id_q] = 1'b1;
        end
    end

    assign uart_valid_o  = (state_q == S_SEND) && req_sel;
    assign uart_data_o   = uart_valid_o ? req_data_i[{grant_id_q, 3'b000} +: 8] : 8'h00;
    assign grant_valid_o = grant_valid_q;
    assign grant_id_o    = grant_id_q;
    assign msg_done_o    = msg_done_q;
    assign len_err_o     = len_err_q;
    assign busy_o        = (state_q != S_IDLE);

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        rr_ptr_d      = rr_ptr_q;
        byte_cnt_d    = byte_cnt_q;
        last_d        = last_q;
        tmr_d         = tmr_q;
        msg_done_d    = 1'b0;
        len_err_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (pick_found) begin
                    grant_id_d    = pick_id;
                    grant_valid_d = 1'b1;
                    byte_cnt_d    = '0;
                    last_d        = 1'b0;
                    state_d       = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                if (!req_sel) begin
                    grant_valid_d = 1'b0;
                    state_d       = S_RELEASE;
                end else if (uart_ready_i) begin
                    byte_cnt_d = (byte_cnt_q == CNTW'(MAX_LEN)) ? byte_cnt_q : byte_cnt_q + CNTW'(1);
                    last_d     = req_last_i[grant_id_q];
                    tmr_d      = '0;
                    state_d    = S_WAIT_LOW;
                end
            end
            // A serializer that never drops ready is assumed to have taken the byte.
            S_WAIT_LOW: begin
                if (!uart_ready_i || (tmr_q == TMRW'(LOW_TIMEOUT - 1))) begin
                    state_d = S_WAIT_HIGH;
                end else begin
                    tmr_d = tmr_q + TMRW'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (uart_ready_i) begin
                    if (last_q) begin
                        msg_done_d    = 1'b1;
                        grant_valid_d = 1'b0;
                        state_d       = S_RELEASE;
                    end else if (byte_cnt_q == CNTW'(MAX_LEN)) begin
                        len_err_d     = 1'b1;
                        grant_valid_d = 1'b0;
                        state_d       = S_RELEASE;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            S_RELEASE: begin
                rr_ptr_d = rr_next;
                tmr_d    = '0;
                state_d  = (GAP_CYCLES != 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (tmr_q == TMRW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMRW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= '0;
            byte_cnt_q    <= '0;
            last_q        <= 1'b0;
            tmr_q         <= '0;
            msg_done_q    <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            rr_ptr_q      <= rr_ptr_d;
            byte_cnt_q    <= byte_cnt_d;
            last_q        <= last_d;
            tmr_q         <= tmr_d;
            msg_done_q    <= msg_done_d;
            len_err_q     <= len_err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: byte-queue sources, a paced uart_tx responder,
// and per-scenario tasks with hand-computed expectations.
module tb_uart_tx_scheduler;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned MAX_LEN     = 4;
    localparam int unsigned GAP_CYCLES  = 3;
    localparam int unsigned LOW_TIMEOUT = 4;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_i;
    logic [8*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_last_i;
    logic [NUM_REQ-1:0]   req_ack_o;
    logic [7:0]           uart_data_o;
    logic                 uart_valid_o;
    logic                 uart_ready_i;
    logic                 grant_valid_o;
    logic [1:0]           grant_id_o;
    logic                 msg_done_o;
    logic                 len_err_o;
    logic                 busy_o;

    int checks = 0;
    int errors = 0;

    // Source byte stores: req stays high while bytes remain unacknowledged.
    logic [7:0] mem      [NUM_REQ][64];
    logic       mem_last [NUM_REQ][64];
    int         src_len  [NUM_REQ];
    int         ack_cnt  [NUM_REQ];

    logic [7:0] cap_q [$];
    logic [1:0] gnt_q [$];
    logic       gv_prev = 1'b0;
    int         n_done  = 0;
    int         n_lerr  = 0;
    int         n_viol  = 0;
    logic       stuck   = 1'b0;
    logic [3:0] ub_cnt  = 4'd0;

    uart_tx_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .MAX_LEN     (MAX_LEN),
        .GAP_CYCLES  (GAP_CYCLES),
        .LOW_TIMEOUT (LOW_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .req_data_i    (req_data_i),
        .req_last_i    (req_last_i),
        .req_ack_o     (req_ack_o),
        .uart_data_o   (uart_data_o),
        .uart_valid_o  (uart_valid_o),
        .uart_ready_i  (uart_ready_i),
        .grant_valid_o (grant_valid_o),
        .grant_id_o    (grant_id_o),
        .msg_done_o    (msg_done_o),
        .len_err_o     (len_err_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_src
        assign req_i[g]            = (ack_cnt[g] < src_len[g]);
        assign req_data_i[8*g +: 8] = mem[g][ack_cnt[g][5:0]];
        assign req_last_i[g]       = mem_last[g][ack_cnt[g][5:0]];
    end

    // uart_tx stand-in: takes a byte on valid&&ready, then holds ready low for 5 cycles.
    always @(posedge clk) begin
        if (uart_valid_o && uart_ready_i) begin
            cap_q.push_back(uart_data_o);
        end
        if (stuck) begin
            uart_ready_i <= 1'b1;
        end else if (uart_valid_o && uart_ready_i) begin
            uart_ready_i <= 1'b0;
            ub_cnt       <= 4'd5;
        end else if (ub_cnt != 4'd0) begin
            ub_cnt <= ub_cnt - 4'd1;
            if (ub_cnt == 4'd1) uart_ready_i <= 1'b1;
        end else begin
            uart_ready_i <= 1'b1;
        end
    end

    always @(posedge clk) begin
        gv_prev <= grant_valid_o;
        if (grant_valid_o && !gv_prev) gnt_q.push_back(grant_id_o);
        if (msg_done_o) n_done <= n_done + 1;
        if (len_err_o)  n_lerr <= n_lerr + 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ack_o[i]) ack_cnt[i] <= ack_cnt[i] + 1;
        end
        if (($countones(req_ack_o) > 1) || ((req_ack_o != '0) && !(uart_valid_o && uart_ready_i)))
            n_viol <= n_viol + 1;
    end

    task automatic push(input int s, input logic [7:0] b, input logic l);
        mem[s][src_len[s][5:0]]      = b;
        mem_last[s][src_len[s][5:0]] = l;
        src_len[s]                   = src_len[s] + 1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy_o || req_i != '0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s drain timeout: busy=%0b req=%b", name, busy_o, req_i);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({uart_valid_o, grant_valid_o, grant_id_o, busy_o, req_ack_o,
             msg_done_o, len_err_o, uart_data_o} !== '0) begin
            errors++;
            $display("FAIL %s outputs: valid=%b gv=%b gid=%0d busy=%b ack=%b done=%b lerr=%b data=%h expected all 0",
                     name, uart_valid_o, grant_valid_o, grant_id_o, busy_o, req_ack_o,
                     msg_done_o, len_err_o, uart_data_o);
        end
        checks++;
        if (dut.rr_ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL %s rr_ptr: got %0d expected 0", name, dut.rr_ptr_q);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_bytes(input string name, input int base, input logic [7:0] exp[$]);
        checks++;
        if (cap_q.size() - base != exp.size()) begin
            errors++;
            $display("FAIL %s byte count: got %0d expected %0d", name, cap_q.size() - base, exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                checks++;
                if (cap_q[base + k] !== exp[k]) begin
                    errors++;
                    $display("FAIL %s byte[%0d]: got %h expected %h", name, k, cap_q[base + k], exp[k]);
                end
            end
        end
    endtask

    task automatic check_grants(input string name, input int base, input logic [1:0] exp[$]);
        checks++;
        if (gnt_q.size() - base != exp.size()) begin
            errors++;
            $display("FAIL %s grant count: got %0d expected %0d", name, gnt_q.size() - base, exp.size());
        end else begin
            for (int k = 0; k < exp.size(); k++) begin
                checks++;
                if (gnt_q[base + k] !== exp[k]) begin
                    errors++;
                    $display("FAIL %s grant[%0d]: got %0d expected %0d", name, k, gnt_q[base + k], exp[k]);
                end
            end
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        checks++;
        if (dut.byte_cnt_q !== '0) begin
            errors++;
            $display("FAIL reset byte_cnt: got %0d expected 0", dut.byte_cnt_q);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int cb, a0, d0, e0, n;
        cb = cap_q.size(); a0 = ack_cnt[0]; d0 = n_done; e0 = n_lerr;
        @(negedge clk);
        push(0, 8'h48, 1'b0);
        push(0, 8'h69, 1'b0);
        push(0, 8'h0A, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!uart_valid_o && n < 10);
        check_int("single latency", n, 2);
        n = 0;
        while (grant_valid_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (busy_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_int("single release+gap cycles", n, GAP_CYCLES + 1);
        check_bytes("single", cb, '{8'h48, 8'h69, 8'h0A});
        check_int("single acks", ack_cnt[0] - a0, 3);
        check_int("single msg_done", n_done - d0, 1);
        check_int("single len_err", n_lerr - e0, 0);
    endtask

    task automatic test_two_sources();
        int cb, gb;
        cb = cap_q.size(); gb = gnt_q.size();
        @(negedge clk);
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b1);
        wait_drain("two");
        check_grants("two", gb, '{2'd1, 2'd2});
        check_bytes("two", cb, '{8'h11, 8'h12, 8'h21, 8'h22});
        check_int("two rr_ptr", int'(dut.rr_ptr_q), 3);
    endtask

    task automatic test_round_robin();
        int cb, gb;
        do_reset();
        cb = cap_q.size(); gb = gnt_q.size();
        for (int s = 0; s < NUM_REQ; s++) begin
            push(s, 8'h30 + 8'(s), 1'b1);
            push(s, 8'h40 + 8'(s), 1'b1);
        end
        wait_drain("rr");
        check_grants("rr", gb, '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3});
        check_bytes("rr", cb, '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h42, 8'h43});
    endtask

    task automatic test_len_err();
        int cb, gb, d0, e0, a0;
        cb = cap_q.size(); gb = gnt_q.size(); d0 = n_done; e0 = n_lerr; a0 = ack_cnt[0];
        @(negedge clk);
        for (int k = 0; k < 4; k++) push(0, 8'hA0 + 8'(k), 1'b0);
        push(1, 8'hB0, 1'b1);
        wait_drain("len");
        check_grants("len", gb, '{2'd0, 2'd1});
        check_bytes("len", cb, '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0});
        check_int("len len_err", n_lerr - e0, 1);
        check_int("len msg_done", n_done - d0, 1);
        check_int("len acks src0", ack_cnt[0] - a0, 4);
    endtask

    task automatic test_reset_mid();
        int a0, n;
        a0 = ack_cnt[0];
        @(negedge clk);
        push(0, 8'hC0, 1'b0);
        push(0, 8'hC1, 1'b0);
        push(0, 8'hC2, 1'b1);
        n = 0;
        while (ack_cnt[0] < a0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_int("midrst byte2 reached", ack_cnt[0] - a0, 2);
        rst = 1'b1;
        src_len[0] = ack_cnt[0];
        push(3, 8'hD3, 1'b1);
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!grant_valid_o && n < 10);
        check_int("midrst grant latency", n, 2);
        check_int("midrst grant id", int'(grant_id_o), 3);
        wait_drain("midrst");
    endtask

    task automatic test_stuck_ready();
        int cb, d0, n;
        cb = cap_q.size(); d0 = n_done;
        @(negedge clk);
        stuck = 1'b1;
        push(2, 8'hE0, 1'b0);
        push(2, 8'hE1, 1'b1);
        n = 0;
        while (!(uart_valid_o && uart_ready_i) && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!uart_valid_o && n < 20);
        check_int("stuck valid-low cycles", n - 1, LOW_TIMEOUT + 1);
        wait_drain("stuck");
        check_bytes("stuck", cb, '{8'hE0, 8'hE1});
        check_int("stuck msg_done", n_done - d0, 1);
        stuck = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int s = 0; s < NUM_REQ; s++) begin
            src_len[s] = 0;
            ack_cnt[s] = 0;
        end
        test_reset();
        test_single();
        test_two_sources();
        test_round_robin();
        test_len_err();
        test_reset_mid();
        test_stuck_ready();
        check_int("ack protocol violations", n_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
